// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: a single full-adder cell is reused for WIDTH
// cycles per operation, with a start/busy/done handshake and held result registers.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] MSB_M1   = CW'(WIDTH - 2);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] ra_reg;
    logic [WIDTH-1:0] rb_reg;
    logic [WIDTH-1:0] part_reg;
    logic [CW-1:0]    cnt_reg;
    logic             carry_reg;
    logic             cin_msb_reg;

    // The one full-adder cell, fed from the LSBs of the operand shifters.
    logic fa_s;
    logic fa_c;
    assign fa_s = ra_reg[0] ^ rb_reg[0] ^ carry_reg;
    assign fa_c = (ra_reg[0] & rb_reg[0]) | (carry_reg & (ra_reg[0] ^ rb_reg[0]));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            ra_reg      <= '0;
            rb_reg      <= '0;
            part_reg    <= '0;
            cnt_reg     <= '0;
            carry_reg   <= 1'b0;
            cin_msb_reg <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sum         <= '0;
            cout        <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
                        ra_reg    <= a;
                        rb_reg    <= sub ? ~b : b;
                        carry_reg <= sub;
                        cnt_reg   <= '0;
                        busy      <= 1'b1;
                        state_reg <= RUN;
                    end else begin
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    part_reg  <= {fa_s, part_reg[WIDTH-1:1]};
                    ra_reg    <= ra_reg >> 1;
                    rb_reg    <= rb_reg >> 1;
                    carry_reg <= fa_c;
                    cnt_reg   <= cnt_reg + CW'(1);
                    // Carry leaving bit WIDTH-2 is the carry into the MSB.
                    if (cnt_reg == MSB_M1) begin
                        cin_msb_reg <= fa_c;
                    end
                    if (cnt_reg == LAST_BIT) begin
                        sum       <= {fa_s, part_reg[WIDTH-1:1]};
                        cout      <= fa_c;
                        ovf       <= ((WIDTH == 2) ? carry_reg : cin_msb_reg) ^ fa_c;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=2, with a
// queue-based scoreboard filled at start and drained on each done pulse.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       reset;
    logic       start8, sub8, busy8, done8, cout8, ovf8;
    logic [7:0] a8, b8, sum8;
    logic       start2, sub2, busy2, done2, cout2, ovf2;
    logic [1:0] a2, b2, sum2;

    int n_checks = 0;
    int n_pass   = 0;

    logic [33:0] q8[$];
    logic [33:0] q2[$];
    logic [33:0] m8, m2;
    logic [7:0]  last_sum8;
    logic [1:0]  last_sum2;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .sub(sub2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Reference: {ovf, cout, sum} from wide arithmetic and operand/result sign rule.
    function automatic logic [33:0] model(input int w, input logic [31:0] x,
                                          input logic [31:0] y, input logic s);
        logic [32:0] mask, yy, t;
        logic [31:0] r;
        logic        c, o;
        mask = (33'd1 << w) - 33'd1;
        yy   = s ? (~{1'b0, y}) & mask : {1'b0, y} & mask;
        t    = {1'b0, x} + yy + {32'd0, s};
        r    = t[31:0] & mask[31:0];
        c    = t[w];
        o    = (x[w-1] == yy[w-1]) && (r[w-1] != x[w-1]);
        return {o, c, r};
    endfunction

    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) check("sb_extra8", 32'd1, 32'd0);
            else begin
                m8 = q8.pop_front();
                $display("w8 done: sum=%h cout=%b ovf=%b (exp %h %b %b)",
                         sum8, cout8, ovf8, m8[7:0], m8[32], m8[33]);
                check("sum8", {24'd0, sum8}, {24'd0, m8[7:0]});
                check("cout8", {31'd0, cout8}, {31'd0, m8[32]});
                check("ovf8", {31'd0, ovf8}, {31'd0, m8[33]});
            end
        end
        if (done2) begin
            if (q2.size() == 0) check("sb_extra2", 32'd1, 32'd0);
            else begin
                m2 = q2.pop_front();
                $display("w2 done: sum=%b cout=%b ovf=%b (exp %b %b %b)",
                         sum2, cout2, ovf2, m2[1:0], m2[32], m2[33]);
                check("sum2", {30'd0, sum2}, {30'd0, m2[1:0]});
                check("cout2", {31'd0, cout2}, {31'd0, m2[32]});
                check("ovf2", {31'd0, ovf2}, {31'd0, m2[33]});
            end
        end
    end

    // One WIDTH=8 operation; returns in the DONE cycle so a following call chains back-to-back.
    task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic isub, input bit poke);
        logic [33:0] e;
        int busy_n, done_k;
        e = model(8, {24'd0, ia}, {24'd0, ib}, isub);
        @(negedge clk);
        start8 = 1'b1; a8 = ia; b8 = ib; sub8 = isub;
        q8.push_back(e);
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
        check("busy_rise8", {31'd0, busy8}, 32'd1);
        check("done_once8", {31'd0, done8}, 32'd0);
        check("hold_run8", {24'd0, sum8}, {24'd0, last_sum8});
        busy_n = busy8 ? 1 : 0;
        done_k = -1;
        for (int k = 1; k <= 10 && done_k < 0; k++) begin
            @(posedge clk); #1;
            start8 = 1'b0;
            if (poke && k == 3) begin
                start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b0;
            end
            if (busy8) busy_n++;
            if (done8) done_k = k;
        end
        start8 = 1'b0;
        check("busy_len8", 32'(busy_n), 32'd8);
        check("done_lat8", 32'(done_k), 32'd8);
        last_sum8 = e[7:0];
    endtask

    task automatic op2(input logic [1:0] ia, input logic [1:0] ib, input logic isub);
        logic [33:0] e;
        int busy_n, done_k;
        e = model(2, {30'd0, ia}, {30'd0, ib}, isub);
        @(negedge clk);
        start2 = 1'b1; a2 = ia; b2 = ib; sub2 = isub;
        q2.push_back(e);
        @(posedge clk); #1;
        start2 = 1'b0; a2 = 2'($urandom); b2 = 2'($urandom); sub2 = 1'($urandom);
        check("hold_run2", {30'd0, sum2}, {30'd0, last_sum2});
        busy_n = busy2 ? 1 : 0;
        done_k = -1;
        for (int k = 1; k <= 6 && done_k < 0; k++) begin
            @(posedge clk); #1;
            if (busy2) busy_n++;
            if (done2) done_k = k;
        end
        check("busy_len2", 32'(busy_n), 32'd2);
        check("done_lat2", 32'(done_k), 32'd2);
        last_sum2 = e[1:0];
    endtask

    initial begin
        int dn;
        reset = 1'b1;
        start8 = 0; sub8 = 0; a8 = '0; b8 = '0;
        start2 = 0; sub2 = 0; a2 = '0; b2 = '0;
        last_sum8 = '0; last_sum2 = '0;
        #12;
        check("rst_busy", {31'd0, busy8}, 32'd0);
        check("rst_done", {31'd0, done8}, 32'd0);
        check("rst_sum", {24'd0, sum8}, 32'd0);
        check("rst_flags", {30'd0, cout8, ovf8}, 32'd0);
        @(negedge clk); reset = 1'b0;

        op8(8'h3C, 8'h05, 1'b0, 0);
        @(posedge clk); #1;
        check("done_pulse8", {31'd0, done8}, 32'd0);
        check("hold_idle8", {24'd0, sum8}, 32'h41);

        op8(8'hFF, 8'h01, 1'b0, 0);
        op8(8'h7F, 8'h01, 1'b0, 0);
        op8(8'h05, 8'h07, 1'b1, 0);
        op8(8'h80, 8'h01, 1'b1, 0);
        repeat (2) @(posedge clk);

        // Ignored mid-RUN start, then a start issued in the DONE cycle.
        op8(8'h10, 8'h01, 1'b0, 1);
        op8(8'h02, 8'h03, 1'b0, 0);
        for (int i = 0; i < 6; i++) op8(8'($urandom), 8'($urandom), 1'($urandom), 0);
        repeat (2) @(posedge clk);

        // Abort an operation at its fourth RUN cycle.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h33; b8 = 8'h44; sub8 = 1'b0;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_busy_pre", {31'd0, busy8}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy8}, 32'd0);
        check("abort_done", {31'd0, done8}, 32'd0);
        check("abort_sum", {24'd0, sum8}, 32'd0);
        check("abort_flags", {30'd0, cout8, ovf8}, 32'd0);
        @(negedge clk); reset = 1'b0;
        last_sum8 = '0;
        dn = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done8) dn++;
        end
        check("abort_no_done", 32'(dn), 32'd0);
        op8(8'h01, 8'h01, 1'b0, 0);

        op2(2'b11, 2'b01, 1'b0);
        op2(2'b10, 2'b10, 1'b0);
        op2(2'b01, 2'b10, 1'b1);
        op2(2'b00, 2'b01, 1'b1);

        repeat (4) @(posedge clk);
        #1;
        check("drain8", 32'(q8.size()), 32'd0);
        check("drain2", 32'(q2.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
